// File: rtl/ppe_psum_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : ppe_psum_scheduler_if
// Description : Bundles the row handshake, timestep pulse, paired RF read
//               port, partial-sum stream, IMEM request stream and status
//               lines of the partial-sum scheduler.
//               master : scheduler side (drives reads, ps, req, status)
//               slave  : environment side (RFs, packetizer, row loader)
// Revision    : 1.0 - initial release
// ============================================================================
interface ppe_psum_scheduler_if #(
    parameter int WEIGHT_WIDTH = 8,
    parameter int SUM_WIDTH    = 13
);
    logic                    row_valid;
    logic                    row_ready;
    logic                    ts_done;
    logic                    rf_rd_en;
    logic [4:0]              i_raddr;
    logic [2:0]              w_raddr;
    logic                    i_rdata;
    logic [WEIGHT_WIDTH-1:0] w_rdata;
    logic                    ps_valid;
    logic                    ps_ready;
    logic [3:0]              ps_dest;
    logic [SUM_WIDTH-1:0]    ps_data;
    logic                    req_valid;
    logic                    req_ready;
    logic [3:0]              req_dest;
    logic [3:0]              req_pe;
    logic                    busy;
    logic                    ts;
    logic [2:0]              row_cnt;

    modport master (
        input  row_valid, ts_done, i_rdata, w_rdata, ps_ready, req_ready,
        output row_ready, rf_rd_en, i_raddr, w_raddr, ps_valid, ps_dest,
               ps_data, req_valid, req_dest, req_pe, busy, ts, row_cnt
    );

    modport slave (
        output row_valid, ts_done, i_rdata, w_rdata, ps_ready, req_ready,
        input  row_ready, rf_rd_en, i_raddr, w_raddr, ps_valid, ps_dest,
               ps_data, req_valid, req_dest, req_pe, busy, ts, row_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ppe_psum_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ppe_psum_scheduler
// Description : Sequencer for one partial-sum PE. For each loaded input row
//               it walks OUTPUT_DIM sliding windows, issuing FILTER_SIZE
//               paired input/weight RF reads per window, accumulates the
//               gated weights, and emits one partial sum per window to a
//               round-robin destination SPE. After a row it requests the next
//               row from IMEM until ROWS_PER_TS rows are done for the timestep.
// Ports       : clk, reset (async, active high)
//               bus (master) : row_valid/row_ready, ts_done, rf_rd_en,
//               i_raddr, w_raddr, i_rdata, w_rdata, ps_valid/ps_ready,
//               ps_dest, ps_data, req_valid/req_ready, req_dest, req_pe,
//               busy, ts, row_cnt
// Revision    : 1.0 - initial release
// ============================================================================
module ppe_psum_scheduler #(
    parameter int FILTER_SIZE  = 5,
    parameter int IFMAP_SIZE   = 25,
    parameter int OUTPUT_DIM   = IFMAP_SIZE - FILTER_SIZE + 1,
    parameter int WEIGHT_WIDTH = 8,
    parameter int SUM_WIDTH    = 13,
    parameter int NUM_SPE      = 5,
    parameter int ROWS_PER_TS  = 5,
    parameter int PE_ID        = 0,
    parameter int IMEM_ID      = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    ppe_psum_scheduler_if.master  bus
);

    localparam logic [4:0] c_OUT_DIM  = 5'(OUTPUT_DIM);
    localparam logic [2:0] c_LAST_W   = 3'(FILTER_SIZE - 1);
    localparam logic [2:0] c_ROWS     = 3'(ROWS_PER_TS);
    localparam logic [3:0] c_LAST_SPE = 4'(NUM_SPE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_EMIT  = 3'd3,
        S_REQ   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           j_q, j_d;
    logic [2:0]           w_q, w_d;
    logic [SUM_WIDTH-1:0] acc_q, acc_d;
    logic [3:0]           dest_q, dest_d;
    logic [2:0]           row_cnt_q, row_cnt_d;
    logic                 ts_q, ts_d;
    logic                 ts_pend_q, ts_pend_d;
    // Set in the cycle after a read strobe: the RFs' data is valid now.
    logic                 rd_pend_q, rd_pend_d;

    logic                 w_row_ready;
    logic [SUM_WIDTH-1:0] w_product;

    assign w_row_ready = (state_q == S_IDLE) && !bus.ts_done && (row_cnt_q < c_ROWS);
    assign w_product   = bus.i_rdata ? {{(SUM_WIDTH-WEIGHT_WIDTH){1'b0}}, bus.w_rdata}
                                     : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            j_q       <= '0;
            w_q       <= '0;
            acc_q     <= '0;
            dest_q    <= '0;
            row_cnt_q <= '0;
            ts_q      <= 1'b0;
            ts_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            w_q       <= w_d;
            acc_q     <= acc_d;
            dest_q    <= dest_d;
            row_cnt_q <= row_cnt_d;
            ts_q      <= ts_d;
            ts_pend_q <= ts_pend_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        w_d       = w_q;
        acc_d     = acc_q;
        dest_d    = dest_q;
        row_cnt_d = row_cnt_q;
        ts_d      = ts_q;
        ts_pend_d = ts_pend_q;
        rd_pend_d = 1'b0;

        // Product of the read issued last cycle (READ with w>0, or DRAIN).
        if (rd_pend_q) begin
            acc_d = acc_q + w_product;
        end

        // A timestep end seen while busy is remembered until IDLE.
        if ((state_q != S_IDLE) && bus.ts_done) begin
            ts_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.ts_done) begin
                    row_cnt_d = '0;
                    ts_d      = 1'b1;
                end else if (bus.row_valid && w_row_ready) begin
                    row_cnt_d = row_cnt_q + 3'd1;
                    j_d       = '0;
                    w_d       = '0;
                    acc_d     = '0;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                rd_pend_d = 1'b1;
                if (w_q == c_LAST_W) begin
                    w_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    w_d = w_q + 3'd1;
                end
            end
            S_DRAIN: begin
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (bus.ps_ready) begin
                    dest_d = (dest_q == c_LAST_SPE) ? 4'd0 : dest_q + 4'd1;
                    j_d    = j_q + 5'd1;
                    acc_d  = '0;
                    w_d    = '0;
                    if ((j_q + 5'd1) < c_OUT_DIM) begin
                        state_d = S_READ;
                    end else if (row_cnt_q < c_ROWS) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_REQ: begin
                if (bus.req_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Deferred timestep end takes effect on the edge entering IDLE.
        if ((state_q != S_IDLE) && (state_d == S_IDLE) && (ts_pend_q || bus.ts_done)) begin
            row_cnt_d = '0;
            ts_d      = 1'b1;
            ts_pend_d = 1'b0;
        end
    end

    assign bus.row_ready = w_row_ready;
    assign bus.rf_rd_en  = (state_q == S_READ);
    assign bus.i_raddr   = (state_q == S_READ) ? (j_q + {2'b00, w_q}) : 5'd0;
    assign bus.w_raddr   = (state_q == S_READ) ? w_q : 3'd0;
    assign bus.ps_valid  = (state_q == S_EMIT);
    assign bus.ps_data   = (state_q == S_EMIT) ? acc_q : '0;
    assign bus.ps_dest   = (state_q == S_EMIT) ? dest_q : 4'd0;
    assign bus.req_valid = (state_q == S_REQ);
    assign bus.req_dest  = 4'(IMEM_ID);
    assign bus.req_pe    = 4'(PE_ID);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.ts        = ts_q;
    assign bus.row_cnt   = row_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ppe_psum_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppe_psum_scheduler
// Description : Self-checking bench for ppe_psum_scheduler. A cycle-level
//               behavioural model (window sums from plain arithmetic, phase
//               and countdown per window) predicts every output; literal
//               expectations pin the model on the directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppe_psum_scheduler;

    localparam int FS = 5, IFM = 25, OD = 21, WW = 8, SW = 13;
    localparam int NSPE = 5, ROWS = 5, PEID = 0, IMID = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ppe_psum_scheduler_if #(.WEIGHT_WIDTH(WW), .SUM_WIDTH(SW)) bus();

    ppe_psum_scheduler #(
        .FILTER_SIZE(FS), .IFMAP_SIZE(IFM), .OUTPUT_DIM(OD), .WEIGHT_WIDTH(WW),
        .SUM_WIDTH(SW), .NUM_SPE(NSPE), .ROWS_PER_TS(ROWS), .PE_ID(PEID), .IMEM_ID(IMID)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- RF contents and read responses ----------------
    logic [IFM-1:0] rf_in = '0;
    logic [WW-1:0]  rf_w [FS];

    always @(posedge clk) begin
        if (bus.rf_rd_en) begin
            bus.i_rdata <= rf_in[bus.i_raddr];
            bus.w_rdata <= rf_w[bus.w_raddr];
        end else begin
            bus.i_rdata <= 1'($urandom);
            bus.w_rdata <= WW'($urandom);
        end
    end

    function automatic int win_sum(input int k);
        int s = 0;
        for (int f = 0; f < FS; f++) if (rf_in[k+f]) s += int'(rf_w[f]);
        return s;
    endfunction

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 computing window (cnt 0..FS-1 reads, FS = drain), 2 emit, 3 request
    int m_phase = 0, m_cnt = 0, m_win = 0, m_rowcnt = 0, m_ts = 0, m_pend = 0, m_dest = 0;
    int m_acc_n = 0, m_acc_cyc = 0;
    int m_sums [OD];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0; m_cnt <= 0; m_win <= 0; m_rowcnt <= 0;
            m_ts <= 0; m_pend <= 0; m_dest <= 0;
        end else begin
            cyc <= cyc + 1;
            case (m_phase)
                0: begin
                    if (bus.ts_done) begin
                        m_rowcnt <= 0; m_ts <= 1;
                    end else if (bus.row_valid && m_rowcnt < ROWS) begin
                        m_rowcnt <= m_rowcnt + 1;
                        m_win <= 0; m_cnt <= 0; m_phase <= 1;
                        m_acc_n <= m_acc_n + 1; m_acc_cyc <= cyc + 1;
                        for (int k = 0; k < OD; k++) m_sums[k] <= win_sum(k);
                    end
                end
                1: begin
                    if (bus.ts_done) m_pend <= 1;
                    if (m_cnt == FS) m_phase <= 2;
                    else m_cnt <= m_cnt + 1;
                end
                2: begin
                    if (bus.ts_done) m_pend <= 1;
                    if (bus.ps_ready) begin
                        m_dest <= (m_dest + 1) % NSPE;
                        m_win <= m_win + 1; m_cnt <= 0;
                        if (m_win + 1 < OD) m_phase <= 1;
                        else if (m_rowcnt < ROWS) m_phase <= 3;
                        else begin
                            m_phase <= 0;
                            if (m_pend != 0 || bus.ts_done) begin
                                m_rowcnt <= 0; m_ts <= 1; m_pend <= 0;
                            end
                        end
                    end
                end
                default: begin
                    if (bus.ts_done) m_pend <= 1;
                    if (bus.req_ready) begin
                        m_phase <= 0;
                        if (m_pend != 0 || bus.ts_done) begin
                            m_rowcnt <= 0; m_ts <= 1; m_pend <= 0;
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    typedef struct { int cyc; int dest; int data; } ps_rec_t;
    ps_rec_t dut_ps [$];
    int req_n = 0;

    always @(negedge clk) begin
        chk("busy", bus.busy, int'(m_phase != 0));
        chk("row_ready", bus.row_ready, int'(m_phase == 0 && !bus.ts_done && m_rowcnt < ROWS));
        chk("row_cnt", bus.row_cnt, m_rowcnt);
        chk("ts", bus.ts, m_ts);
        chk("rf_rd_en", bus.rf_rd_en, int'(m_phase == 1 && m_cnt < FS));
        if (m_phase == 1 && m_cnt < FS) begin
            chk("i_raddr", bus.i_raddr, m_win + m_cnt);
            chk("w_raddr", bus.w_raddr, m_cnt);
        end
        chk("ps_valid", bus.ps_valid, int'(m_phase == 2));
        if (m_phase == 2) begin
            chk("ps_data", bus.ps_data, m_sums[m_win]);
            chk("ps_dest", bus.ps_dest, m_dest);
        end
        chk("req_valid", bus.req_valid, int'(m_phase == 3));
        chk("req_dest", bus.req_dest, IMID);
        chk("req_pe", bus.req_pe, PEID);
        if (bus.ps_valid && bus.ps_ready) dut_ps.push_back('{cyc, int'(bus.ps_dest), int'(bus.ps_data)});
        if (bus.req_valid && bus.req_ready) req_n++;
    end

    // ---------------- stimulus ----------------
    int rnd = 0;
    int stall_win = -1;
    int stall_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (m_phase == 2 && m_win == stall_win && stall_cnt > 0) begin
            bus.ps_ready = 1'b0;
            stall_cnt--;
        end else begin
            bus.ps_ready = (rnd != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        bus.req_ready = (rnd != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    task automatic pulse_ts();
        bus.ts_done = 1'b1;
        tick();
        bus.ts_done = 1'b0;
    endtask

    task automatic load_row(input logic [IFM-1:0] bits, input logic [FS*WW-1:0] wts);
        int n0;
        rf_in = bits;
        for (int f = 0; f < FS; f++) rf_w[f] = wts[f*WW +: WW];
        n0 = m_acc_n;
        bus.row_valid = 1'b1;
        for (int t = 0; t < 200 && m_acc_n == n0; t++) tick();
        chk("row_accept_timeout", int'(m_acc_n != n0), 1);
        bus.row_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 4000 && m_phase != 0; t++) tick();
        chk("idle_timeout", int'(m_phase == 0), 1);
    endtask

    localparam logic [FS*WW-1:0] W12345 = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [FS*WW-1:0] W255   = {FS*WW{1'b1}};

    initial begin
        int pb, rb, psn;
        bus.row_valid = 1'b0; bus.ts_done = 1'b0;
        bus.ps_ready = 1'b1; bus.req_ready = 1'b1;
        bus.i_rdata = 1'b0; bus.w_rdata = '0;
        for (int f = 0; f < FS; f++) rf_w[f] = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_busy", bus.busy, 0);
        chk("reset_row_ready", bus.row_ready, 1);
        chk("reset_ps_valid", bus.ps_valid, 0);
        chk("reset_req_dest", bus.req_dest, 10);
        chk("reset_row_cnt", bus.row_cnt, 0);

        // Row 1: all ones, weights 1..5
        pb = dut_ps.size(); rb = req_n;
        load_row({IFM{1'b1}}, W12345);
        wait_idle();
        chk("t1_packets", dut_ps.size() - pb, 21);
        chk("t1_data0", dut_ps[pb].data, 15);
        chk("t1_data20", dut_ps[pb+20].data, 15);
        chk("t1_dest1", dut_ps[pb+1].dest, 1);
        chk("t1_dest5", dut_ps[pb+5].dest, 0);
        chk("t1_latency_edges", dut_ps[pb].cyc - m_acc_cyc, 6);
        chk("t1_reqs", req_n - rb, 1);

        // Row 2: only bit 0 set
        pb = dut_ps.size();
        load_row(25'd1, W12345);
        wait_idle();
        chk("t2_data0", dut_ps[pb].data, 1);
        chk("t2_data1", dut_ps[pb+1].data, 0);
        chk("t2_data20", dut_ps[pb+20].data, 0);

        // Row 3: all weights 255
        pb = dut_ps.size();
        load_row({IFM{1'b1}}, W255);
        wait_idle();
        chk("t3_data10", dut_ps[pb+10].data, 1275);

        // Row 4: 10-cycle backpressure at window 3
        pb = dut_ps.size();
        stall_win = 3; stall_cnt = 10;
        load_row(IFM'($urandom), FS*WW'({$urandom, $urandom}));
        wait_idle();
        stall_win = -1;
        chk("t4_stall_gap", dut_ps[pb+3].cyc - dut_ps[pb+2].cyc, 17);
        chk("t4_next_gap", dut_ps[pb+4].cyc - dut_ps[pb+3].cyc, 7);

        // Row 5: last row of the timestep, no request afterwards
        load_row(IFM'($urandom), FS*WW'({$urandom, $urandom}));
        wait_idle();
        chk("t5_total_reqs", req_n, 4);
        bus.row_valid = 1'b1;
        repeat (5) tick();
        chk("t5_blocked_busy", bus.busy, 0);
        chk("t5_blocked_ready", bus.row_ready, 0);
        bus.row_valid = 1'b0;
        pulse_ts();
        chk("t5_ts_row_cnt", bus.row_cnt, 0);
        chk("t5_ts", bus.ts, 1);

        // Row 6 with ts_done mid-row (deferred)
        load_row(IFM'($urandom), W12345);
        repeat (20) tick();
        pulse_ts();
        chk("t6_deferred_row_cnt", bus.row_cnt, 1);
        wait_idle();
        chk("t6_applied_row_cnt", bus.row_cnt, 0);

        // ts_done together with row_valid in IDLE
        bus.row_valid = 1'b1; bus.ts_done = 1'b1;
        tick();
        bus.ts_done = 1'b0;
        chk("t7_not_same_edge", bus.busy, 0);
        tick();
        chk("t7_next_edge", bus.busy, 1);
        bus.row_valid = 1'b0;
        wait_idle();

        // Randomized rows, ready signals and timestep pulses
        rnd = 1;
        for (int r = 0; r < 7; r++) begin
            wait_idle();
            if (m_rowcnt == ROWS) pulse_ts();
            load_row(IFM'($urandom), FS*WW'({$urandom, $urandom}));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 120)) tick();
                pulse_ts();
            end
            wait_idle();
        end
        rnd = 0;
        if (m_rowcnt == ROWS) pulse_ts();

        // Reset during READ of window 2
        load_row({IFM{1'b1}}, W12345);
        for (int t = 0; t < 200 && !(m_phase == 1 && m_win == 2 && m_cnt == 2); t++) tick();
        chk("t9_in_read", bus.rf_rd_en, 1);
        chk("t9_window2_addr", bus.i_raddr, 4);
        psn = dut_ps.size();
        #2 reset = 1'b1;
        #1;
        chk("t9_rst_busy", bus.busy, 0);
        chk("t9_rst_rd_en", bus.rf_rd_en, 0);
        chk("t9_rst_ps_valid", bus.ps_valid, 0);
        chk("t9_rst_row_cnt", bus.row_cnt, 0);
        chk("t9_rst_ts", bus.ts, 0);
        chk("t9_rst_req_pe", bus.req_pe, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("t9_no_ps_emitted", dut_ps.size() - psn, 0);
        pb = dut_ps.size();
        load_row({IFM{1'b1}}, W12345);
        wait_idle();
        chk("t9_first_dest", dut_ps[pb].dest, 0);
        chk("t9_first_data", dut_ps[pb].data, 15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire
